// File: rtl/ibus_responder_pkg.sv
// ibus_responder_pkg: shared ibus request/response types and responder FSM states
package ibus_responder_pkg;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;
    typedef struct packed {
        logic valid;
        u64   addr;
    } ibus_req_t;
    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u32   data;
    } ibus_resp_t;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} ibus_state_t;
endpackage

// File: rtl/ibus_mem_array.sv
// ibus_mem_array: word memory with registered read, read-before-write on same-index collision
module ibus_mem_array
    import ibus_responder_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output u32                       rdata,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  u32                       wdata
);
    u32 mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdata;
        if (re) rdata <= mem[ridx];
    end
endmodule

// File: rtl/ibus_responder.sv
// ibus_responder: ibus slave answering fetch requests from a loadable memory after LATENCY wait cycles
module ibus_responder
    import ibus_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1,
    parameter u64 BASE    = 64'h8000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  ibus_req_t                ireq,
    output ibus_resp_t               iresp,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  u32                       load_data
);
    ibus_state_t state;
    logic [3:0]  cnt;
    u64          addr_q;
    u64          woff;
    u32          rdata;
    logic        oob;
    logic        re;
    assign woff = (addr_q - BASE) >> 2;
    assign oob  = (addr_q < BASE) || (woff >= 64'(DEPTH));
    assign re   = (state == WAIT) && ireq.valid && (cnt == 4'd0);
    ibus_mem_array #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .re    (re),
        .ridx  (woff[$clog2(DEPTH)-1:0]),
        .rdata (rdata),
        .we    (load_en),
        .widx  (load_idx),
        .wdata (load_data)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            iresp  <= '0;
        end else begin
            iresp <= '0;
            case (state)
                IDLE: if (ireq.valid) begin
                    addr_q <= ireq.addr;
                    cnt    <= 4'(LATENCY - 1);
                    state  <= WAIT;
                end
                WAIT: if (!ireq.valid) state <= IDLE;
                      else if (cnt == 4'd0) state <= RESP;
                      else cnt <= cnt - 4'd1;
                RESP: begin
                    iresp <= '{addr_ok: 1'b1, data_ok: 1'b1, data: oob ? '0 : rdata};
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // the fetch side must hold the address steady while a request is pending
    addr_stable: assert property (@(posedge clk) disable iff (reset)
        (state == WAIT && ireq.valid) |-> (ireq.addr == addr_q));
endmodule

// File: tb/tb_ibus_responder.sv
// tb_ibus_responder: scoreboard bench for ibus_responder at LATENCY 1 and 4
module tb_ibus_responder;
    import ibus_responder_pkg::*;
    typedef struct {
        int cyc;
        u32 data;
    } exp_t;
    logic       clk;
    logic       reset;
    ibus_req_t  ireq1, ireq4;
    ibus_resp_t iresp1, iresp4;
    logic       load_en;
    logic [3:0] load_idx;
    u32         load_data;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_on = 0;
    exp_t       q1[$], q4[$];
    exp_t       e1, e4;
    u32         init_words [16];
    int         c;
    ibus_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .ireq(ireq1), .iresp(iresp1),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
    );
    ibus_responder #(.DEPTH(16), .LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .ireq(ireq4), .iresp(iresp4),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) if (mon_on) begin
        if (iresp1.data_ok) begin
            check("d1_pending", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                check("d1_cycle", 64'(cyc), 64'(e1.cyc));
                check("d1_data", 64'(iresp1.data), 64'(e1.data));
                check("d1_addr_ok", 64'(iresp1.addr_ok), 64'd1);
            end
        end else check("d1_idle", 64'(iresp1), 64'd0);
    end
    always @(negedge clk) if (mon_on) begin
        if (iresp4.data_ok) begin
            check("d4_pending", 64'(q4.size() != 0), 64'd1);
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                check("d4_cycle", 64'(cyc), 64'(e4.cyc));
                check("d4_data", 64'(iresp4.data), 64'(e4.data));
                check("d4_addr_ok", 64'(iresp4.addr_ok), 64'd1);
            end
        end else check("d4_idle", 64'(iresp4), 64'd0);
    end
    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask
    task automatic load(input int idx, input u32 d);
        load_en   = 1'b1;
        load_idx  = 4'(idx);
        load_data = d;
    endtask
    // valid first sampled at edge cyc+1, so data_ok shows at cyc+LATENCY+2
    task automatic req(input bit four, input u64 addr, input u32 data);
        int c0;
        int l;
        c0 = cyc;
        l  = four ? 4 : 1;
        if (four) begin
            ireq4 = '{valid: 1'b1, addr: addr};
            q4.push_back('{c0 + l + 2, data});
        end else begin
            ireq1 = '{valid: 1'b1, addr: addr};
            q1.push_back('{c0 + l + 2, data});
        end
        wait_cyc(c0 + l + 2);
        if (four) ireq4.valid = 1'b0;
        else ireq1.valid = 1'b0;
    endtask
    initial begin
        init_words = '{32'h0000_0513, 32'h0010_0593, 32'h1234_5678, 32'hCAFE_F00D,
                       32'h4444_4444, 32'h5555_0005, 32'h6666_0006, 32'h7777_0007,
                       32'h8888_0008, 32'h9999_0009, 32'hAAAA_000A, 32'hBBBB_000B,
                       32'hCCCC_000C, 32'hDDDD_000D, 32'hEEEE_000E, 32'hFFFF_FFFF};
        reset = 1'b1;
        ireq1 = '0;
        ireq4 = '0;
        load_en = 1'b0;
        load_idx = '0;
        load_data = '0;
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        check("rst_iresp1", 64'(iresp1), 64'd0);
        check("rst_iresp4", 64'(iresp4), 64'd0);
        check("rst_state1", 64'(dut1.state), 64'(IDLE));
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            load(i, init_words[i]);
            @(negedge clk);
        end
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        // back-to-back at LATENCY 1: address switched while the first is in RESP
        c = cyc;
        ireq1 = '{valid: 1'b1, addr: 64'h8000_0000};
        q1.push_back('{c + 3, 32'h0000_0513});
        wait_cyc(c + 2);
        ireq1.addr = 64'h8000_0004;
        q1.push_back('{c + 6, 32'h0010_0593});
        wait_cyc(c + 6);
        ireq1.valid = 1'b0;
        repeat (2) @(negedge clk);
        req(1'b0, 64'h7FFF_FFFC, 32'h0);
        req(1'b0, 64'h8000_0040, 32'h0);
        req(1'b1, 64'h8000_0008, 32'h1234_5678);
        req(1'b1, 64'h7FFF_FFFC, 32'h0);
        repeat (2) @(negedge clk);
        // abort at t+2, fresh request at t+4
        c = cyc;
        ireq4 = '{valid: 1'b1, addr: 64'h8000_000C};
        wait_cyc(c + 2);
        ireq4.valid = 1'b0;
        wait_cyc(c + 4);
        ireq4.valid = 1'b1;
        q4.push_back('{c + 10, 32'hCAFE_F00D});
        wait_cyc(c + 10);
        ireq4.valid = 1'b0;
        repeat (2) @(negedge clk);
        // load lands on the read edge: old word returned
        c = cyc;
        ireq1 = '{valid: 1'b1, addr: 64'h8000_0008};
        q1.push_back('{c + 3, 32'h1234_5678});
        wait_cyc(c + 1);
        load(2, 32'hDEAD_BEEF);
        wait_cyc(c + 2);
        load_en = 1'b0;
        wait_cyc(c + 3);
        ireq1.valid = 1'b0;
        @(negedge clk);
        req(1'b0, 64'h8000_0008, 32'hDEAD_BEEF);
        req(1'b1, 64'h8000_000A, 32'hDEAD_BEEF);
        // load before the read edge: new word returned
        c = cyc;
        ireq4 = '{valid: 1'b1, addr: 64'h8000_0010};
        q4.push_back('{c + 6, 32'hA5A5_0004});
        wait_cyc(c + 2);
        load(4, 32'hA5A5_0004);
        wait_cyc(c + 3);
        load_en = 1'b0;
        wait_cyc(c + 6);
        ireq4.valid = 1'b0;
        repeat (2) @(negedge clk);
        // reset during WAIT with valid still held
        c = cyc;
        ireq4 = '{valid: 1'b1, addr: 64'h8000_0000};
        wait_cyc(c + 2);
        reset = 1'b1;
        wait_cyc(c + 3);
        reset = 1'b0;
        ireq4.valid = 1'b0;
        check("rst_wait_state", 64'(dut4.state), 64'(IDLE));
        wait_cyc(c + 12);
        check("rst_wait_q4", 64'(q4.size()), 64'd0);
        req(1'b1, 64'h8000_0000, 32'h0000_0513);
        repeat (4) @(negedge clk);
        check("end_q1", 64'(q1.size()), 64'd0);
        check("end_q4", 64'(q4.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
